// File: rtl/tcp_tx_pkg.sv
// tcp_tx_pkg: shared TCP transmit header type, flag bits and arbiter state encoding
package tcp_tx_pkg;
  typedef struct packed {
    logic [15:0] ip_len;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  flags;
    logic [15:0] window;
    logic [31:0] dst_ip;
    logic        no_data;
  } tcp_tx_hdr_t;
  localparam logic [7:0] TCP_FIN = 8'h01;
  localparam logic [7:0] TCP_SYN = 8'h02;
  localparam logic [7:0] TCP_RST = 8'h04;
  localparam logic [7:0] TCP_PSH = 8'h08;
  localparam logic [7:0] TCP_ACK = 8'h10;
  typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, ptr in; gnt_onehot, gnt_idx out), first set bit at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx
);
  int j;
  always_comb begin
    gnt_onehot = '0;
    gnt_idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) gnt_idx = W'(j);
    end
    gnt_onehot[gnt_idx] = |req;
  end
endmodule

// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: round-robin share of one tcp_packet_generator (req/ack/done per requester, latched header and payload mux to generator)
module tcp_tx_arbiter
  import tcp_tx_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  tcp_tx_hdr_t [N_REQ-1:0]     i_req_hdr,
  output logic [N_REQ-1:0]            o_req_ack,
  output logic [N_REQ-1:0]            o_done,
  input  logic [N_REQ-1:0][7:0]       s_tdata,
  input  logic [N_REQ-1:0]            s_tvalid,
  input  logic [N_REQ-1:0]            s_tlast,
  output logic [N_REQ-1:0]            s_tready,
  output logic                        o_hdr_valid,
  input  logic                        i_hdr_ready,
  output logic [15:0]                 o_ip_len,
  output logic [31:0]                 o_seq_number,
  output logic [31:0]                 o_ack_number,
  output logic [15:0]                 o_source_port,
  output logic [15:0]                 o_dest_port,
  output logic [7:0]                  o_flags,
  output logic [15:0]                 o_window_size,
  output logic [31:0]                 o_dst_ip,
  output logic                        o_no_data,
  output logic [7:0]                  m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,
  input  logic                        i_packet_done,
  output logic                        o_busy
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  state_t state_q, state_d;
  logic [PW-1:0] grant_q, grant_d, ptr_q, ptr_d, gnt_idx;
  tcp_tx_hdr_t hdr_q, hdr_d;
  logic [N_REQ-1:0] ack_q, ack_d, done_q, done_d, gnt_onehot;
  logic act;
  rr_arbiter #(.N(N_REQ), .W(PW)) u_rr (
    .req(i_req),
    .ptr(ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx(gnt_idx)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    hdr_d = hdr_q;
    ack_d = '0;
    done_d = '0;
    case (state_q)
      IDLE: if (|i_req) begin
        state_d = HDR;
        grant_d = gnt_idx;
        hdr_d = i_req_hdr[gnt_idx];
        ack_d = gnt_onehot;
        ptr_d = (N_REQ == 1 || gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
      HDR: state_d = i_hdr_ready ? STREAM : HDR;
      STREAM: if (i_packet_done) begin
        state_d = IDLE;
        done_d[grant_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      hdr_q <= '0;
      ack_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      hdr_q <= hdr_d;
      ack_q <= ack_d;
      done_q <= done_d;
    end
  end
  assign act = state_q != IDLE;
  assign o_busy = act;
  assign o_hdr_valid = state_q == HDR;
  assign o_req_ack = ack_q;
  assign o_done = done_q;
  // routing is live from HDR on; the generator holds tready low until it wants data
  assign m_tdata = act ? s_tdata[grant_q] : '0;
  assign m_tvalid = act & s_tvalid[grant_q];
  assign m_tlast = act & s_tlast[grant_q];
  always_comb begin
    s_tready = '0;
    s_tready[grant_q] = act & m_tready;
  end
  assign o_ip_len = hdr_q.ip_len;
  assign o_seq_number = hdr_q.seq;
  assign o_ack_number = hdr_q.ack;
  assign o_source_port = hdr_q.src_port;
  assign o_dest_port = hdr_q.dst_port;
  assign o_flags = hdr_q.flags;
  assign o_window_size = hdr_q.window;
  assign o_dst_ip = hdr_q.dst_ip;
  assign o_no_data = hdr_q.no_data;
endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// tb_tcp_tx_arbiter: directed and random checks of tcp_tx_arbiter against a packet-level reference model
module tb_tcp_tx_arbiter;
  import tcp_tx_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] i_req, o_req_ack, o_done, s_tvalid, s_tlast, s_tready;
  tcp_tx_hdr_t [N-1:0] req_hdr;
  logic [N-1:0][7:0] s_tdata;
  logic o_hdr_valid, i_hdr_ready, o_no_data, m_tvalid, m_tlast, m_tready, i_packet_done, o_busy;
  logic [15:0] o_ip_len, o_source_port, o_dest_port, o_window_size;
  logic [31:0] o_seq_number, o_ack_number, o_dst_ip;
  logic [7:0] o_flags, m_tdata;
  always #5 clk = ~clk;
  tcp_tx_arbiter #(.N_REQ(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_req_hdr(req_hdr),
    .o_req_ack(o_req_ack), .o_done(o_done),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .o_hdr_valid(o_hdr_valid), .i_hdr_ready(i_hdr_ready),
    .o_ip_len(o_ip_len), .o_seq_number(o_seq_number), .o_ack_number(o_ack_number),
    .o_source_port(o_source_port), .o_dest_port(o_dest_port), .o_flags(o_flags),
    .o_window_size(o_window_size), .o_dst_ip(o_dst_ip), .o_no_data(o_no_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .i_packet_done(i_packet_done), .o_busy(o_busy)
  );
  int tests = 0, fails = 0;
  int phase = 0, g = 0, rp = 0, last_len = 0;
  tcp_tx_hdr_t ref_hdr, h;
  logic [N-1:0] exp_ack, exp_done;
  logic [7:0] pay [N][$];
  logic [7:0] exp_pkt[$], rx[$];
  int rstate [N];
  int dcount [N];
  int order[$];
  logic done_pend;
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic tcp_tx_hdr_t rand_hdr(logic nd);
    tcp_tx_hdr_t x;
    x.ip_len = 16'($urandom);
    x.seq = $urandom;
    x.ack = $urandom;
    x.src_port = 16'($urandom);
    x.dst_port = 16'($urandom);
    x.flags = 8'($urandom);
    x.window = 16'($urandom);
    x.dst_ip = $urandom;
    x.no_data = nd;
    return x;
  endfunction
  function automatic bit all_idle();
    for (int r = 0; r < N; r++) if (rstate[r] != 0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic drive_req();
    for (int r = 0; r < N; r++) begin
      s_tvalid[r] = pay[r].size() > 0;
      s_tlast[r] = pay[r].size() == 1;
      s_tdata[r] = pay[r].size() > 0 ? pay[r][0] : 8'($urandom);
    end
  endtask
  task automatic start_req(int r, tcp_tx_hdr_t hh, int len);
    pay[r].delete();
    for (int i = 0; i < len; i++) pay[r].push_back(8'($urandom));
    req_hdr[r] = hh;
    i_req[r] = 1'b1;
    rstate[r] = 1;
    drive_req();
  endtask
  task automatic clear_env();
    for (int r = 0; r < N; r++) begin
      pay[r].delete();
      rstate[r] = 0;
    end
    i_req = '0;
    done_pend = 1'b0;
    drive_req();
  endtask
  task automatic tick();
    logic [N-1:0] pre_req, hs_s, exp_rdy;
    logic hs_m, m_l, rs, pd;
    logic [7:0] m_d;
    int err;
    pre_req = i_req;
    rs = rst;
    pd = i_packet_done;
    hs_s = s_tvalid & s_tready;
    hs_m = m_tvalid & m_tready;
    m_d = m_tdata;
    m_l = m_tlast;
    exp_ack = '0;
    exp_done = '0;
    for (int r = 0; r < N; r++) if (hs_s[r] && pay[r].size() > 0) void'(pay[r].pop_front());
    if (hs_m) begin
      rx.push_back(m_d);
      if (m_l) done_pend = 1'b1;
    end
    if (rs) begin
      phase = 0; rp = 0; g = 0; ref_hdr = '0; done_pend = 1'b0; rx.delete();
    end else if (phase == 0) begin
      if (|pre_req) begin
        for (int k = 0; k < N; k++) begin
          if (pre_req[(rp + k) % N]) begin
            g = (rp + k) % N;
            break;
          end
        end
        rp = (g + 1) % N;
        ref_hdr = req_hdr[g];
        exp_ack[g] = 1'b1;
        exp_pkt = pay[g];
        rx.delete();
        order.push_back(g);
        phase = 1;
      end
    end else if (phase == 1) begin
      if (i_hdr_ready) begin
        phase = 2;
        if (ref_hdr.no_data) done_pend = 1'b1;
      end
    end else if (pd) begin
      phase = 0;
      exp_done[g] = 1'b1;
      last_len = rx.size();
      chk("payload_len", rx.size(), exp_pkt.size());
      err = 0;
      for (int i = 0; i < rx.size() && i < exp_pkt.size(); i++) if (rx[i] !== exp_pkt[i]) err++;
      chk("payload_bytes", err, 0);
    end
    @(posedge clk);
    #2;
    for (int r = 0; r < N; r++) begin
      if (exp_ack[r]) begin
        i_req[r] = 1'b0;
        rstate[r] = 2;
        req_hdr[r] = rand_hdr(1'b0);
      end
      if (exp_done[r]) begin
        rstate[r] = 0;
        dcount[r]++;
      end
    end
    i_packet_done = done_pend | (phase != 2 && $urandom_range(0, 7) == 0);
    done_pend = 1'b0;
    m_tready = phase == 2 ? ($urandom_range(0, 3) != 0) : 1'b0;
    i_hdr_ready = 1'($urandom_range(0, 1));
    drive_req();
    #1;
    exp_rdy = '0;
    if (phase != 0) exp_rdy[g] = m_tready;
    chk("req_ack", o_req_ack, exp_ack);
    chk("done", o_done, exp_done);
    chk("busy", o_busy, phase != 0);
    chk("hdr_valid", o_hdr_valid, phase == 1);
    chk("s_tready", s_tready, exp_rdy);
    chk("m_tvalid", m_tvalid, phase != 0 && s_tvalid[g]);
    chk("hdr_out", {o_ip_len, o_seq_number, o_ack_number, o_source_port, o_dest_port,
                    o_flags, o_window_size, o_dst_ip, o_no_data}, ref_hdr);
  endtask
  task automatic wait_all(string tag, int cap);
    for (int c = 0; c < cap && !all_idle(); c++) tick();
    tests++;
    assert (all_idle()) else begin
      fails++;
      $error("FAIL %s timeout observed=busy expected=all requesters served", tag);
    end
  endtask
  task automatic chk_zero(string tag);
    chk(tag, {o_req_ack, o_done, s_tready, o_hdr_valid, m_tvalid, m_tlast, m_tdata, o_busy,
              o_ip_len, o_seq_number, o_ack_number, o_source_port, o_dest_port,
              o_flags, o_window_size, o_dst_ip, o_no_data}, '0);
  endtask
  task automatic do_reset();
    clear_env();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int ord;
    rst = 1'b1;
    req_hdr = '0;
    i_hdr_ready = 1'b0;
    m_tready = 1'b0;
    i_packet_done = 1'b0;
    ref_hdr = '0;
    for (int r = 0; r < N; r++) dcount[r] = 0;
    clear_env();
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset_state");
    h = rand_hdr(1'b0);
    h.seq = 32'h1000;
    start_req(2, h, 5);
    tick();
    chk("single_ack", o_req_ack, 4'b0100);
    chk("single_seq", o_seq_number, 32'h1000);
    wait_all("single", 200);
    chk("single_done_count", dcount[2], 1);
    chk("single_len", last_len, 5);
    chk("single_busy_drop", o_busy, 1'b0);
    do_reset();
    order.delete();
    for (int r = 0; r < N; r++) start_req(r, rand_hdr(1'($urandom_range(0, 1))), $urandom_range(1, 4));
    for (int r = 0; r < N; r++) if (req_hdr[r].no_data) pay[r].delete();
    drive_req();
    wait_all("all4", 400);
    start_req(0, rand_hdr(1'b0), 2);
    wait_all("all4_again", 100);
    ord = 0;
    for (int i = 0; i < order.size(); i++) ord = ord * 16 + order[i];
    chk("rr_order", ord, 32'h01230);
    start_req(1, rand_hdr(1'b0), 3);
    wait_all("fair_a", 100);
    start_req(0, rand_hdr(1'b0), 3);
    start_req(1, rand_hdr(1'b0), 3);
    wait_all("fair_b", 200);
    chk("fair_pick", order[order.size() - 2], 0);
    h = rand_hdr(1'b0);
    h.flags = TCP_SYN;
    start_req(0, h, 6);
    tick();
    req_hdr[0].flags = TCP_ACK;
    tick();
    tick();
    chk("flags_hold", o_flags, TCP_SYN);
    wait_all("hold", 200);
    start_req(1, rand_hdr(1'b0), 6);
    tick();
    start_req(3, rand_hdr(1'b0), 4);
    tick();
    tick();
    chk("iso_tready3", s_tready[3], 1'b0);
    wait_all("iso", 300);
    for (int c = 0; c < 800; c++) begin
      tick();
      for (int r = 0; r < N; r++) begin
        if (rstate[r] == 0 && $urandom_range(0, 7) == 0) begin
          logic nd;
          nd = $urandom_range(0, 4) == 0;
          start_req(r, rand_hdr(nd), nd ? 0 : $urandom_range(1, 6));
        end
      end
    end
    wait_all("drain", 800);
    start_req(0, rand_hdr(1'b0), 6);
    for (int c = 0; c < 50 && phase != 2; c++) tick();
    tick();
    tests++;
    assert (phase == 2) else begin
      fails++;
      $error("FAIL mid_stream_reach observed=phase %0d expected=2", phase);
    end
    do_reset();
    chk_zero("rst_mid");
    start_req(0, rand_hdr(1'b0), 3);
    tick();
    chk("regrant0", o_req_ack, 4'b0001);
    wait_all("after_rst", 200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tcp_tx_arbiter.md
# tcp_tx_arbiter

Round-robin scheduler that shares one `tcp_packet_generator` among `N_REQ` TCP transmit requesters, e.g. per-socket state machines. It grants one requester at a time and latches that requester's header into a stable register. It drives the generator's header inputs, routes the granted requester's payload stream to the generator, and holds the grant until the generator reports packet completion. It sits between the socket engines and the single `tcp_packet_generator` feeding the IP layer.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (1..16)

Ports:
- `i_clk`  in  1  system clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_req`  in  N_REQ  per-requester transmit request (level)
- `i_req_hdr`  in  N_REQ x tcp_tx_hdr_t  per-requester header; sampled only at grant
- `o_req_ack`  out  N_REQ  one-cycle pulse: header latched; requester may drop `i_req` and change `i_req_hdr`
- `o_done`  out  N_REQ  one-cycle pulse: requester's packet fully sent
- `s_tdata`  in  N_REQ x 8  per-requester payload byte
- `s_tvalid`, `s_tlast`  in  N_REQ  per-requester payload valid/last
- `s_tready`  out  N_REQ  per-requester payload ready
- `o_hdr_valid`  out  1  to generator `i_hdr_valid`
- `i_hdr_ready`  in  1  IP-layer `ip_hdr_ready` (header accepted when `o_hdr_valid & i_hdr_ready`)
- `o_ip_len`, `o_seq_number`, `o_ack_number`, `o_source_port`, `o_dest_port`, `o_flags`, `o_window_size`, `o_dst_ip`, `o_no_data`  out  per tcp_tx_hdr_t  latched header fields to generator
- `m_tdata` (out, 8), `m_tvalid` (out, 1), `m_tlast` (out, 1), `m_tready` (in, 1): payload stream to the generator's `s_axis_data`
- `i_packet_done`  in  1  generator `o_packet_done`
- `o_busy`  out  1  grant held (state != IDLE)

## Operation
- States: IDLE, HDR, STREAM.
- **IDLE.** If any `i_req` bit is set, pick the first set bit at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - On the next edge: latch `i_req_hdr[g]` into `hdr_q`, set `grant_q = g`, set `rr_ptr = (g+1) mod N_REQ`, pulse `o_req_ack[g]`, and go to HDR.
- **HDR.** `o_hdr_valid = 1`. When `i_hdr_ready` is high, go to STREAM the next cycle.
- **STREAM.**
  - `m_tdata/m_tvalid/m_tlast` = granted requester's signals.
  - `s_tready[grant_q] = m_tready`; all other `s_tready` bits are 0.
  - When `i_packet_done` is high, go to IDLE and pulse `o_done[grant_q]` on the next cycle.
- Payload routing is also active in HDR. The generator's tready is 0 until it enters DATA_CHECKSUM, so no data is lost.
- Header outputs always reflect `hdr_q` and stay stable from the grant until return to IDLE. The generator reads them live during its HEADER state, so this stability is mandatory.
- `o_no_data` passes through from `hdr_q`. The arbiter does not check that a no_data requester sends no payload.

## Timing
- Reset: state IDLE, `rr_ptr=0`, `grant_q=0`, `hdr_q=0`. All outputs are 0, including `o_req_ack`, `o_done`, `s_tready`, `o_hdr_valid`, `m_tvalid` and `o_busy`.
- Grant latency: `i_req` rises in IDLE → `o_req_ack` and `o_busy` are high the next cycle, and `o_hdr_valid` is high the same cycle.
- Turnaround: `i_packet_done` at cycle t → IDLE at t+1 with `o_done` pulse at t+1 → next grant latched at t+2 at the earliest.
- `i_packet_done` or `i_hdr_ready` while in IDLE is ignored. `i_packet_done` in HDR is ignored.
- A requester that drops `i_req` before the grant is not served. Dropping it after `o_req_ack` has no effect on the current packet.
- A new `i_req` that arrives while busy waits; no preemption.
- `N_REQ=1`: `rr_ptr` is held at 0 and its register width is clamped to 1 bit.
- Reset mid-packet: immediate return to reset values. The generator shares `i_rst`.

## Structure
- Shared package `tcp_tx_pkg`:
  - `typedef struct packed tcp_tx_hdr_t { ip_len[15:0], seq[31:0], ack[31:0], src_port[15:0], dst_port[15:0], flags[7:0], window[15:0], dst_ip[31:0], no_data }`.
  - TCP flag bit constants (FIN, SYN, RST, PSH, ACK).
- Sub-module `rr_arbiter #(N)`: combinational round-robin pick from `req` and `ptr`, outputs `gnt_onehot` and `gnt_idx`.
- Everything else stays in the top level, sized 150–250 lines.

## Test plan
- Single request: req[2] with seq=0x1000 and no_data=0 sends 5 payload bytes.
  - → ack[2] on the next cycle; generator sees seq=0x1000 and 5 bytes with tlast on the 5th; done[2] pulses once; `o_busy` then drops.
- All four requesters asserted together from reset → grants in order 0,1,2,3, then 0 again if re-requested; each `o_done` precedes the next `o_req_ack`.
- rr fairness: after req[1] is served, req[0] and req[1] both pending → grant goes to 0.
- Header stability: requester changes `i_req_hdr` (flags 0x02→0x10) after ack → generator still emits flags 0x02 for the whole packet.
- Non-granted isolation: requester 3 holds tvalid=1 while requester 1 is granted → `s_tready[3]` stays 0 and only requester 1's bytes reach `m_tdata`.
- Reset asserted mid-STREAM → next cycle all outputs are 0 and state is IDLE; a fresh req[0] is granted normally.
